rv_multicycle_controller: RTL and testbench
===========================================

Name: rv_multicycle_controller

Overview:
Control FSM for the multicycle RV32I datapath variant: sequences fetch, decode, address/execute, memory and writeback over several cycles, sharing one ALU and one unified memory port. Sits beside the datapath. Consumes the opcode from the instruction register, the ALU zero flag and a memory ready handshake. Drives all datapath mux selects and write enables, and keeps a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of the instret counter (wraps modulo 2^CNT_WIDTH)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from the instruction register, stable after FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_write  out  1  write qualifier for mem_req
adr_src  out  1  0 = PC, 1 = ALUOut
ir_write  out  1  latch instruction register and OldPC
pc_write  out  1  PC write enable
reg_write  out  1  register file write enable
alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
imm_src  out  2  00 I, 01 S, 10 B
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
illegal_instr  out  1  unsupported opcode seen in DECODE
state  out  4  current state, for debug
instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BEQ=10. Codes 11-15 return to IDLE.
- Reset (async, rst_n=0): state=IDLE and instret=0. In IDLE every output is 0.
- IDLE goes to FETCH unconditionally on the first edge after reset release.
- Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready (combinational).
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=10 (precomputes the branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ.
  - Any other opcode -> FETCH, with illegal_instr=1 for this cycle only and no retire.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; imm_src=01 if opcode=0100011, else 00. Next state is MEMWRITE for a store, else MEMREAD.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, result_src=01. Next state FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Holds until mem_ready=1, then goes to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, imm_src=00. Next state ALUWB.
- ALUWB: reg_write=1, result_src=00. Next state FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=zero (combinational). Next state FETCH.
- instret increments by 1 on the edge that leaves any of these: MEMWB, ALUWB, BEQ (taken or not), or MEMWRITE with mem_ready=1. There is at most one increment per edge.
- Latency with mem_ready tied high:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and I-type: 4 cycles.
  - branch: 3 cycles.
- Reset asserted mid-instruction: immediate return to IDLE, outputs 0, instret cleared. An in-flight memory request is dropped.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset then release, mem_ready=1 -> IDLE (all outputs 0) for 1 cycle, then FETCH with mem_req=1, ir_write=1, pc_write=1, alu_src_b=10.
- lw (opcode 0000011), mem_ready=1 -> states 1,2,3,4,5,1; reg_write=1 and result_src=01 only in MEMWB; instret 0->1.
- sw (0100011), mem_ready low for 3 cycles in MEMWRITE -> mem_req=1, mem_write=1 and imm_src=01 in MEMADR; MEMWRITE held 4 cycles; instret increments once, on exit.
- beq (1100011) with zero=1, then zero=0 -> pc_write=1 in BEQ for the first, 0 for the second; alu_op=01; instret +2 in total.
- R-type (0110011) then I-type (0010011) -> EXECR alu_src_b=00, EXECI alu_src_b=01, both alu_op=10; ALUWB reg_write=1.
- Opcode 1111111 -> illegal_instr=1 for one cycle in DECODE, then FETCH, instret unchanged. Separately, rst_n=0 during MEMREAD -> IDLE asynchronously and instret=0.

Source files
------------

// File: rtl/rv_multicycle_controller.sv
// ---------------------------------------------------------------------------
// rv_multicycle_controller
//
// Control FSM for the multicycle RV32I datapath. It sequences each
// instruction through FETCH, DECODE, address/execute, memory and writeback.
// The datapath has one shared ALU and one unified memory port, so every
// select and write enable for that datapath is driven from here. The block
// also keeps a retired-instruction counter.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   opcode         instr[6:0] from the instruction register (stable after FETCH)
//   zero           ALU zero flag (branch condition)
//   mem_ready      memory completes the current request this cycle
//   mem_req        memory request
//   mem_write      write qualifier for mem_req
//   adr_src        memory address select: 0 = PC, 1 = ALUOut
//   ir_write       latch instruction register and OldPC
//   pc_write       PC write enable
//   reg_write      register file write enable
//   alu_src_a      00 PC, 01 OldPC, 10 RD1
//   alu_src_b      00 RD2, 01 ImmExt, 10 constant 4
//   alu_op         00 add, 01 sub, 10 funct-decoded
//   imm_src        00 I, 01 S, 10 B
//   result_src     00 ALUOut, 01 Data, 10 ALUResult
//   illegal_instr  unsupported opcode seen in DECODE (one cycle)
//   state          current state code, for debug
//   instret        retired instruction count, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module rv_multicycle_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           imm_src,
  output logic [1:0]           result_src,
  output logic                 illegal_instr,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Moore-type controls; these are registered alongside the state.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q;
  state_t               state_next;
  ctrl_t                ctrl_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 retire;
  logic                 opcode_legal;

  // Control word for a given state. The opcode input is used only to pick
  // the immediate format in MEMADR. It is sampled while the state is
  // DECODE, and the instruction register already holds a stable value then.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        // Precompute the branch target (OldPC + B-imm) into ALUOut.
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 2'b10;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = (op == OP_STORE) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b01;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first. Without one, a path that does not assign it infers a latch.
    opcode_legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: opcode_legal = 1'b1;
      default:                                          opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = S_IDLE;
    case (state_q)
      S_IDLE:     state_next = S_FETCH;
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_IDLE;   // unused codes 11-15 recover
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  // These final states are mutually exclusive, so at most one increment
  // happens per edge.
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                  (state_q == S_BEQ)   ||
                  ((state_q == S_MEMWRITE) && mem_ready);

  // The control word is loaded from the next state, so the registered
  // outputs line up with the state register in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_next;
      ctrl_q  <= ctrl_for(state_next, opcode);
      if (retire) instret_q <= instret_q + CNT_ONE;
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_write  = ctrl_q.mem_write;
  assign adr_src    = ctrl_q.adr_src;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign imm_src    = ctrl_q.imm_src;
  assign result_src = ctrl_q.result_src;

  // These depend on same-cycle inputs, so they stay combinational.
  // FETCH latches IR/OldPC and advances the PC in the cycle the memory
  // answers. BEQ loads the precomputed target when the compare is equal.
  assign ir_write      = (state_q == S_FETCH) && mem_ready;
  assign pc_write      = ((state_q == S_FETCH) && mem_ready) ||
                         ((state_q == S_BEQ) && zero);
  assign illegal_instr = (state_q == S_DECODE) && !opcode_legal;

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_rv_multicycle_controller
//
// Directed bench for rv_multicycle_controller. Inputs are driven and outputs
// are sampled on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_rv_multicycle_controller;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_write;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  imm_src;
  logic [1:0]  result_src;
  logic        illegal_instr;
  logic [3:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = '0;

  logic [16:0] all_outs;
  assign all_outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, alu_op, imm_src, result_src,
                     illegal_instr};

  rv_multicycle_controller #(.CNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .imm_src       (imm_src),
    .result_src    (result_src),
    .illegal_instr (illegal_instr),
    .state         (state),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (all_outs !== 17'h0) begin errors++; $display("FAIL reset_outs got %h exp 0", all_outs); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
    rst_n = 1'b1;
    #1;
    checks++; if (state !== 4'd0 || all_outs !== 17'h0) begin
      errors++; $display("FAIL idle_after_release state %0d outs %h exp 0/0", state, all_outs); end
    tick();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL fetch_state got %0d exp 1", state); end
    checks++; if ({mem_req, ir_write, pc_write, adr_src} !== 4'b1110) begin
      errors++; $display("FAIL fetch_req_ir_pc got %b exp 1110", {mem_req, ir_write, pc_write, adr_src}); end
    checks++; if ({alu_src_a, alu_src_b, alu_op, result_src} !== 8'b00_10_00_10) begin
      errors++; $display("FAIL fetch_alu got %b exp 00100010", {alu_src_a, alu_src_b, alu_op, result_src}); end
  endtask

  task automatic test_fetch_stall();
    mem_ready = 1'b0;
    #1;
    checks++; if ({ir_write, pc_write} !== 2'b00) begin
      errors++; $display("FAIL stall_ir_pc got %b exp 00", {ir_write, pc_write}); end
    tick();
    checks++; if (state !== 4'd1 || mem_req !== 1'b1) begin
      errors++; $display("FAIL stall_hold state %0d req %b exp 1/1", state, mem_req); end
    mem_ready = 1'b1;
    #1;
    checks++; if ({ir_write, pc_write} !== 2'b11) begin
      errors++; $display("FAIL stall_release_ir_pc got %b exp 11", {ir_write, pc_write}); end
  endtask

  task automatic test_lw();
    int seq[5] = '{2, 3, 4, 5, 1};
    logic [1:0] exp_rs;
    opcode = 7'b0000011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_rs = (seq[i] == 5) ? 2'b01 : (seq[i] == 1) ? 2'b10 : 2'b00;
      checks++; if (state !== 4'(seq[i])) begin
        errors++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, seq[i]); end
      checks++; if (reg_write !== (seq[i] == 5) || result_src !== exp_rs) begin
        errors++; $display("FAIL lw_wb[%0d] reg_write %b result_src %b exp %b/%b",
                           i, reg_write, result_src, (seq[i] == 5), exp_rs); end
      if (seq[i] == 4) begin
        checks++; if ({mem_req, adr_src, mem_write} !== 3'b110) begin
          errors++; $display("FAIL lw_memread got %b exp 110", {mem_req, adr_src, mem_write}); end
      end
      if (seq[i] == 3) begin
        checks++; if (imm_src !== 2'b00 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin
          errors++; $display("FAIL lw_memadr imm %b a %b b %b exp 00/10/01", imm_src, alu_src_a, alu_src_b); end
      end
      if (i == 4) exp_instret++;
      checks++; if (instret !== exp_instret) begin
        errors++; $display("FAIL lw_instret[%0d] got %0d exp %0d", i, instret, exp_instret); end
    end
  endtask

  task automatic test_sw_wait();
    opcode = 7'b0100011; mem_ready = 1'b1;
    tick();
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL sw_decode got %0d exp 2", state); end
    tick();
    checks++; if (state !== 4'd3 || imm_src !== 2'b01 || mem_req !== 1'b0) begin
      errors++; $display("FAIL sw_memadr state %0d imm %b req %b exp 3/01/0", state, imm_src, mem_req); end
    mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (state !== 4'd6 || {mem_req, mem_write, adr_src} !== 3'b111) begin
        errors++; $display("FAIL sw_memwrite[%0d] state %0d ctl %b exp 6/111", c, state, {mem_req, mem_write, adr_src}); end
      checks++; if (instret !== exp_instret) begin
        errors++; $display("FAIL sw_hold_instret[%0d] got %0d exp %0d", c, instret, exp_instret); end
      if (c == 4) mem_ready = 1'b1;
    end
    tick();
    exp_instret++;
    checks++; if (state !== 4'd1 || instret !== exp_instret) begin
      errors++; $display("FAIL sw_exit state %0d instret %0d exp 1/%0d", state, instret, exp_instret); end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      opcode = 7'b1100011; mem_ready = 1'b1; zero = (k == 0);
      tick();
      checks++; if (state !== 4'd2 || imm_src !== 2'b10 || alu_src_a !== 2'b01 || alu_src_b !== 2'b01) begin
        errors++; $display("FAIL beq_decode[%0d] state %0d imm %b a %b b %b", k, state, imm_src, alu_src_a, alu_src_b); end
      tick();
      checks++; if (state !== 4'd10 || alu_op !== 2'b01 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
        errors++; $display("FAIL beq_state[%0d] state %0d op %b a %b b %b exp 10/01/10/00", k, state, alu_op, alu_src_a, alu_src_b); end
      checks++; if (pc_write !== (k == 0)) begin
        errors++; $display("FAIL beq_pc_write[%0d] got %b exp %b", k, pc_write, (k == 0)); end
      tick();
      exp_instret++;
      checks++; if (state !== 4'd1 || instret !== exp_instret) begin
        errors++; $display("FAIL beq_exit[%0d] state %0d instret %0d exp 1/%0d", k, state, instret, exp_instret); end
    end
    zero = 1'b0;
  endtask

  task automatic test_r_i();
    logic [6:0] ops[2] = '{7'b0110011, 7'b0010011};
    logic [3:0] exp_st;
    logic [1:0] exp_b;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; mem_ready = 1'b1;
      exp_st = (k == 0) ? 4'd7 : 4'd8;
      exp_b  = (k == 0) ? 2'b00 : 2'b01;
      tick();
      tick();
      checks++; if (state !== exp_st || alu_src_b !== exp_b || alu_op !== 2'b10 ||
                    alu_src_a !== 2'b10 || imm_src !== 2'b00) begin
        errors++; $display("FAIL exec[%0d] state %0d b %b op %b a %b imm %b exp %0d/%b/10/10/00",
                           k, state, alu_src_b, alu_op, alu_src_a, imm_src, exp_st, exp_b); end
      tick();
      checks++; if (state !== 4'd9 || reg_write !== 1'b1 || result_src !== 2'b00) begin
        errors++; $display("FAIL aluwb[%0d] state %0d rw %b rs %b exp 9/1/00", k, state, reg_write, result_src); end
      tick();
      exp_instret++;
      checks++; if (state !== 4'd1 || instret !== exp_instret) begin
        errors++; $display("FAIL alu_exit[%0d] state %0d instret %0d exp 1/%0d", k, state, instret, exp_instret); end
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111; mem_ready = 1'b1;
    tick();
    checks++; if (state !== 4'd2 || illegal_instr !== 1'b1) begin
      errors++; $display("FAIL illegal_decode state %0d ill %b exp 2/1", state, illegal_instr); end
    tick();
    checks++; if (state !== 4'd1 || illegal_instr !== 1'b0 || instret !== exp_instret) begin
      errors++; $display("FAIL illegal_exit state %0d ill %b instret %0d exp 1/0/%0d",
                         state, illegal_instr, instret, exp_instret); end
  endtask

  task automatic test_reset_midflight();
    opcode = 7'b0000011; mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    checks++; if (state !== 4'd4 || mem_req !== 1'b1 || instret !== exp_instret) begin
      errors++; $display("FAIL mid_memread state %0d req %b instret %0d exp 4/1/%0d",
                         state, mem_req, instret, exp_instret); end
    #2 rst_n = 1'b0;
    #1;
    exp_instret = '0;
    checks++; if (state !== 4'd0 || all_outs !== 17'h0 || instret !== exp_instret) begin
      errors++; $display("FAIL mid_async_reset state %0d outs %h instret %0d exp 0/0/0", state, all_outs, instret); end
    tick();
    rst_n = 1'b1; mem_ready = 1'b1;
    tick();
    checks++; if (state !== 4'd1 || mem_req !== 1'b1) begin
      errors++; $display("FAIL mid_restart state %0d req %b exp 1/1", state, mem_req); end
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_lw();
    test_sw_wait();
    test_beq();
    test_r_i();
    test_illegal();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
